// File: rtl/led_pwm.sv
// Eight-channel LED PWM driver with a double-buffered duty bank.
// New duties are applied only at a period boundary, so the pins never glitch.
module led_pwm #(
  parameter int PRESCALE   = 255,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] duty_data,
  input  logic        duty_valid,
  output logic        duty_ready,
  output logic [7:0]  leds,
  output logic        period_start
);

  localparam logic [15:0] PRE_MAX  = 16'(PRESCALE);
  localparam logic [7:0]  LEDS_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [15:0] pre_p0;
  logic [7:0]  phase_p0;
  logic [63:0] active_p0;
  logic [63:0] pending_p0;
  logic        pend_full;
  logic        tick;
  logic        boundary;
  logic        accept;
  logic [7:0]  lit_p0;

  function automatic logic [7:0] pin_drive(input logic [7:0] lit);
    return ACTIVE_LOW ? ~lit : lit;
  endfunction

  assign tick       = (pre_p0 == PRE_MAX);
  assign boundary   = tick && (phase_p0 == 8'hFF);
  assign duty_ready = !pend_full && !reset;
  assign accept     = duty_valid && duty_ready;

  // Stage p0: phase against the active duty bank
  always_comb begin
    lit_p0 = '0;
    for (int i = 0; i < 8; i++) begin
      lit_p0[i] = (phase_p0 < active_p0[8*i +: 8]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_p0     <= '0;
      phase_p0   <= '0;
      active_p0  <= '0;
      pending_p0 <= '0;
      pend_full  <= 1'b0;
    end else begin
      pre_p0 <= tick ? 16'd0 : pre_p0 + 16'd1;
      if (tick) begin
        phase_p0 <= phase_p0 + 8'd1;
      end
      // A write can only land while the buffer is empty, so it never races the apply
      if (accept) begin
        pending_p0 <= duty_data;
        pend_full  <= 1'b1;
      end else if (boundary && pend_full) begin
        active_p0 <= pending_p0;
        pend_full <= 1'b0;
      end
    end
  end

  // Stage p1: registered pin drive and period marker
  always_ff @(posedge clock) begin
    if (reset) begin
      leds         <= LEDS_OFF;
      period_start <= 1'b0;
    end else begin
      leds         <= pin_drive(lit_p0);
      period_start <= boundary;
    end
  end

endmodule

// File: tb/tb_led_pwm.sv
// Scoreboard bench for led_pwm: two instances (fast active-low, slower active-high)
// compared cycle by cycle against a time-based reference model.
module tb_led_pwm;

  localparam int PRE_A = 0;
  localparam int PRE_B = 3;

  typedef struct packed {
    logic [7:0] leds;
    logic       ps;
    logic       full;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] data_a = '0, data_b = '0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        ready_a, ready_b;
  logic [7:0]  leds_a, leds_b;
  logic        ps_a, ps_b;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  exp_t        q_a[$];
  exp_t        q_b[$];
  int unsigned m_t[2];
  logic [63:0] m_act[2];
  logic [63:0] m_pend[2];
  logic        m_full[2];
  int          last_ps[2];

  led_pwm #(.PRESCALE(PRE_A), .ACTIVE_LOW(1'b1)) dut_a (
    .clock(clk), .reset(reset), .duty_data(data_a), .duty_valid(valid_a),
    .duty_ready(ready_a), .leds(leds_a), .period_start(ps_a)
  );

  led_pwm #(.PRESCALE(PRE_B), .ACTIVE_LOW(1'b0)) dut_b (
    .clock(clk), .reset(reset), .duty_data(data_b), .duty_valid(valid_b),
    .duty_ready(ready_b), .leds(leds_b), .period_start(ps_b)
  );

  always #5 clk = ~clk;

  function automatic int unsigned period_len(input int k);
    return 256 * ((k == 0) ? PRE_A + 1 : PRE_B + 1);
  endfunction

  // Reference: phase and boundary derived from elapsed cycles since reset release
  task automatic model_step(input int k, input logic rst, input logic vld, input logic [63:0] d);
    int unsigned p1;
    int unsigned len;
    int unsigned ph;
    logic        bnd;
    logic [7:0]  lit;
    logic        al;
    exp_t        e;
    p1  = (k == 0) ? PRE_A + 1 : PRE_B + 1;
    len = 256 * p1;
    al  = (k == 0);
    if (rst) begin
      m_t[k]    = 0;
      m_act[k]  = '0;
      m_pend[k] = '0;
      m_full[k] = 1'b0;
      e.leds = al ? 8'hFF : 8'h00;
      e.ps   = 1'b0;
      e.full = 1'b0;
    end else begin
      ph  = (m_t[k] / p1) % 256;
      bnd = ((m_t[k] % len) == len - 1);
      for (int i = 0; i < 8; i++) lit[i] = (ph < 32'(m_act[k][8*i +: 8]));
      if (vld && !m_full[k]) begin
        m_pend[k] = d;
        m_full[k] = 1'b1;
      end else if (bnd && m_full[k]) begin
        m_act[k]  = m_pend[k];
        m_full[k] = 1'b0;
      end
      m_t[k] = m_t[k] + 1;
      e.leds = al ? ~lit : lit;
      e.ps   = bnd;
      e.full = m_full[k];
    end
    if (k == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  always @(posedge clk) begin
    model_step(0, reset, valid_a, data_a);
    model_step(1, reset, valid_b, data_b);
  end

  task automatic check_inst(input int k, input logic [7:0] l, input logic ps, input logic rdy);
    exp_t  e;
    string nm;
    nm = (k == 0) ? "a" : "b";
    checks++;
    if ((k == 0 && q_a.size() == 0) || (k == 1 && q_b.size() == 0)) begin
      fails++;
      $display("FAIL %s_queue cyc=%0d got=empty required=entry", nm, cyc);
      return;
    end
    if (k == 0) e = q_a.pop_front();
    else        e = q_b.pop_front();
    if (l !== e.leds) begin
      fails++;
      $display("FAIL %s_leds cyc=%0d got=%h required=%h", nm, cyc, l, e.leds);
    end
    checks++;
    if (ps !== e.ps) begin
      fails++;
      $display("FAIL %s_period_start cyc=%0d got=%b required=%b", nm, cyc, ps, e.ps);
    end
    checks++;
    if (rdy !== (!e.full && !reset)) begin
      fails++;
      $display("FAIL %s_duty_ready cyc=%0d got=%b required=%b", nm, cyc, rdy, !e.full && !reset);
    end
    if (reset) begin
      last_ps[k] = -1;
    end else if (ps === 1'b1) begin
      if (last_ps[k] >= 0) begin
        checks++;
        if (cyc - last_ps[k] != int'(period_len(k))) begin
          fails++;
          $display("FAIL %s_spacing cyc=%0d got=%0d required=%0d", nm, cyc, cyc - last_ps[k], period_len(k));
        end
      end
      last_ps[k] = cyc;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    check_inst(0, leds_a, ps_a, ready_a);
    check_inst(1, leds_b, ps_b, ready_b);
  end

  // Offer data and hold it until accepted (bounded)
  task automatic do_write(input int k, input logic [63:0] d);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    #1;
    if (k == 0) begin data_a = d; valid_a = 1'b1; end
    else        begin data_b = d; valid_b = 1'b1; end
    while (!ok && n <= 2 * int'(period_len(k)) + 10) begin
      @(negedge clk);
      ok = (k == 0) ? ready_a : ready_b;
      n++;
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL write_timeout inst=%0d got=no_accept required=accept", k);
    end else begin
      @(posedge clk);
      #1;
    end
    if (k == 0) valid_a = 1'b0;
    else        valid_b = 1'b0;
  endtask

  task automatic wait_ps(input int k);
    int   n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n <= int'(period_len(k)) + 10) begin
      @(negedge clk);
      seen = (k == 0) ? ps_a : ps_b;
      n++;
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("FAIL period_start_timeout inst=%0d got=none required=pulse", k);
    end
  endtask

  initial begin
    last_ps[0] = -1;
    last_ps[1] = -1;
    // Reset for 3 cycles with a write in flight that must be discarded
    valid_a = 1'b1;
    data_a  = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    reset   = 1'b0;
    valid_a = 1'b0;

    // Duty 128 on channel 0 only, written right after reset
    do_write(0, 64'h0000_0000_0000_0080);
    do_write(1, {$urandom, $urandom});
    repeat (3 * 256) @(posedge clk);

    // Extremes: channel 1 duty 0, channel 2 duty 255
    do_write(0, {40'h0, 8'hFF, 8'h00, 8'($urandom)});
    repeat (2 * 256 + 20) @(posedge clk);

    // Back-pressure: A then B held until the first boundary consumes A
    do_write(0, {8{8'h40}});
    do_write(0, {8{8'hC0}});
    wait_ps(0);

    // Write presented on the boundary cycle itself
    wait_ps(0);
    repeat (255) @(posedge clk);
    do_write(0, {8{8'h10}});
    repeat (2 * 256 + 10) @(posedge clk);

    // Reset mid-period with an active duty and a pending write
    do_write(0, {8{8'h80}});
    wait_ps(0);
    do_write(0, {$urandom, $urandom});
    repeat (98) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (600) @(posedge clk);

    // Randomised writes to both instances at random gaps
    for (int it = 0; it < 10; it++) begin
      int gap;
      int k;
      gap = $urandom_range(0, 300);
      k   = $urandom_range(0, 1);
      repeat (gap) @(posedge clk);
      do_write(k, {$urandom, $urandom});
    end
    repeat (1100) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
